// File: rtl/tone_sweep_ctrl.sv
// rtl/tone_sweep_ctrl.sv - NCO tone sweep sequencer with framed FFT capture (optional TONE_SWEEP_LOOP_EN adds loop input)
`timescale 1ns/1ps

module tone_sweep_ctrl #(
  parameter int DEPTH     = 4,
  parameter int IDX_W     = 2,
  parameter int FRAME_LEN = 1024,
  parameter int SETTLE    = 16,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [31:0]      cfg_data,
  input  logic [IDX_W:0]   cfg_num,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_valid,
  input  logic             fft_ready,
`ifdef TONE_SWEEP_LOOP_EN
  input  logic             loop,
`endif
  output logic [31:0]      phi_inc,
  output logic             nco_clken,
  output logic [IDX_W-1:0] tone_idx,
  output logic             frame_valid,
  output logic             frame_sop,
  output logic             frame_eop,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_SETTLE   = 3'd2;
  localparam logic [2:0] S_WAIT_RDY = 3'd3;
  localparam logic [2:0] S_CAPTURE  = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [IDX_W:0]   DEPTH_N     = (IDX_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_LEN - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W:0]   num;
  logic [31:0]      tbl [DEPTH];

  logic             idle_like;
  logic [IDX_W:0]   num_clamped;
  logic [IDX_W:0]   num_last;
  logic             last_tone;
  logic             wrap_en;

  assign idle_like   = (state == S_IDLE) || (state == S_DONE);
  assign num_clamped = (cfg_num > DEPTH_N) ? DEPTH_N : cfg_num;
  assign num_last    = num - (IDX_W+1)'(1);
  assign last_tone   = ({1'b0, tone_idx} == num_last);

`ifdef TONE_SWEEP_LOOP_EN
  assign wrap_en = loop;
`else
  assign wrap_en = 1'b0;
`endif

  // Frame qualifiers are combinational so they line up with the NCO sample; stop kills them at once.
  assign frame_valid = (state == S_CAPTURE) && sample_valid && !stop;
  assign frame_sop   = frame_valid && (cnt == '0);
  assign frame_eop   = frame_valid && (cnt == FRAME_LAST);

  // Tone table: host writes only land while no sweep is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else if (cfg_we && idle_like) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // Sweep sequencer: load tone, settle, wait for sink, capture one frame, advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      num       <= '0;
      tone_idx  <= '0;
      phi_inc   <= '0;
      nco_clken <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // Abort from any state; phi_inc and tone_idx keep their last values.
        state     <= S_IDLE;
        busy      <= 1'b0;
        nco_clken <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              if (cfg_num != '0) begin
                num      <= num_clamped;
                tone_idx <= '0;
                state    <= S_LOAD;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            phi_inc   <= tbl[tone_idx];
            nco_clken <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= S_SETTLE;
          end
          S_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              state <= S_WAIT_RDY;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_WAIT_RDY: begin
            if (fft_ready) begin
              cnt   <= '0;
              state <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (sample_valid) begin
              if (cnt == FRAME_LAST) begin
                state <= S_NEXT;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          S_NEXT: begin
            if (last_tone) begin
              if (wrap_en) begin
                tone_idx <= '0;
                state    <= S_LOAD;
              end else begin
                state     <= S_DONE;
                done      <= 1'b1;
                busy      <= 1'b0;
                nco_clken <= 1'b0;
              end
            end else begin
              tone_idx <= tone_idx + IDX_W'(1);
              state    <= S_LOAD;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_sweep_ctrl.sv
// tb/tb_tone_sweep_ctrl.sv - self-checking bench for tone_sweep_ctrl
`timescale 1ns/1ps

module tb_tone_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [2:0]  cfg_num;
  logic        start;
  logic        stop;
  logic        sample_valid;
  logic        fft_ready;
`ifdef TONE_SWEEP_LOOP_EN
  logic        loop;
`endif
  logic [31:0] phi_inc;
  logic        nco_clken;
  logic [1:0]  tone_idx;
  logic        frame_valid;
  logic        frame_sop;
  logic        frame_eop;
  logic        busy;
  logic        done;

  tone_sweep_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_num      (cfg_num),
    .start        (start),
    .stop         (stop),
    .sample_valid (sample_valid),
    .fft_ready    (fft_ready),
`ifdef TONE_SWEEP_LOOP_EN
    .loop         (loop),
`endif
    .phi_inc      (phi_inc),
    .nco_clken    (nco_clken),
    .tone_idx     (tone_idx),
    .frame_valid  (frame_valid),
    .frame_sop    (frame_sop),
    .frame_eop    (frame_eop),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // sample_valid pattern: 0 = held high, 1 = toggling every cycle, 2 = held low
  int sv_mode = 0;

  // Monitor state, written only by the monitor process.
  logic mon_clr = 1'b0;
  int   cyc = 0;
  int   sop_cnt, eop_cnt, done_cnt, vtotal, fcnt, proto_err, first_clken;
  logic clken_q;
  int   phi_seen  [8];
  int   tidx_seen [8];
  int   sop_cyc   [8];
  int   flen_seen [8];
  int   span_seen [8];

  int tbl_m [4];

  typedef struct {
    int num;
    int sv;
    int dly;
    int frames;
    int dones;
    int span;
    int lat;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic wr(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = 2'(addr);
    cfg_data = 32'(data);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic kick(input int num);
    cfg_num = 3'(num);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_sops(input int n);
    for (int i = 0; i < 20000; i++) begin
      if (sop_cnt >= n) break;
      tick();
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000; i++) begin
      if (done_cnt > 0) break;
      tick();
    end
  endtask

  task automatic wait_clken();
    for (int i = 0; i < 200; i++) begin
      if (first_clken >= 0) break;
      tick();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phi_inc"},     int'(phi_inc), 0);
    chk({tag, "_nco_clken"},   int'(nco_clken), 0);
    chk({tag, "_tone_idx"},    int'(tone_idx), 0);
    chk({tag, "_frame_valid"}, int'(frame_valid), 0);
    chk({tag, "_frame_sop"},   int'(frame_sop), 0);
    chk({tag, "_frame_eop"},   int'(frame_eop), 0);
    chk({tag, "_busy"},        int'(busy), 0);
    chk({tag, "_done"},        int'(done), 0);
  endtask

  // sample_valid driver, updated just after each rising edge
  initial begin
    sample_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sv_mode == 1) sample_valid = ~sample_valid;
      else              sample_valid = (sv_mode == 0);
    end
  end

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_clr) begin
      sop_cnt = 0; eop_cnt = 0; done_cnt = 0; vtotal = 0; fcnt = 0;
      proto_err = 0; first_clken = -1; clken_q = nco_clken;
    end else begin
      if (nco_clken && !clken_q && first_clken < 0) first_clken = cyc;
      clken_q = nco_clken;
      if (done) done_cnt = done_cnt + 1;
      if ((frame_sop || frame_eop) && !frame_valid) proto_err = proto_err + 1;
      if (frame_valid) begin
        if (frame_sop) begin
          if (sop_cnt < 8) begin
            phi_seen[sop_cnt]  = int'(phi_inc);
            tidx_seen[sop_cnt] = int'(tone_idx);
            sop_cyc[sop_cnt]   = cyc;
          end
          sop_cnt = sop_cnt + 1;
          fcnt = 0;
        end
        fcnt = fcnt + 1;
        vtotal = vtotal + 1;
        if (frame_eop) begin
          if (eop_cnt < 8) begin
            flen_seen[eop_cnt] = fcnt;
            span_seen[eop_cnt] = cyc - sop_cyc[eop_cnt] + 1;
          end
          eop_cnt = eop_cnt + 1;
        end
      end
    end
  end

  initial begin
    tbl_m = '{8589935, 64424509, 85899346, 0};
    //           num sv dly frames dones span lat
    vecs[0] = '{3, 0, 0,  3, 1, 1024, 17};
    vecs[1] = '{1, 0, 50, 1, 1, 1024, 67};
    vecs[2] = '{2, 1, 0,  2, 1, 2047, -1};
    vecs[3] = '{7, 0, 0,  4, 1, 1024, 17};
    vecs[4] = '{0, 0, 0,  0, 1, 0,    -1};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_num = '0;
    start = 1'b0; stop = 1'b0; fft_ready = 1'b1;
`ifdef TONE_SWEEP_LOOP_EN
    loop = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) wr(i, tbl_m[i]);

    // Table-driven full sweeps
    for (int v = 0; v < NV; v++) begin
      clear_mon();
      sv_mode   = vecs[v].sv;
      fft_ready = (vecs[v].dly == 0);
      kick(vecs[v].num);
      if (vecs[v].frames > 0) begin
        wait_clken();
        if (vecs[v].dly > 0) begin
          repeat (15 + vecs[v].dly) tick();
          chk($sformatf("v%0d_rdy_hold_no_valid", v), sop_cnt + vtotal, 0);
          fft_ready = 1'b1;
        end
      end
      wait_done();
      tick();
      tick();
      chk($sformatf("v%0d_sops", v), sop_cnt, vecs[v].frames);
      chk($sformatf("v%0d_eops", v), eop_cnt, vecs[v].frames);
      chk($sformatf("v%0d_dones", v), done_cnt, vecs[v].dones);
      chk($sformatf("v%0d_proto", v), proto_err, 0);
      chk($sformatf("v%0d_clken_rose", v), (first_clken >= 0) ? 1 : 0, (vecs[v].frames > 0) ? 1 : 0);
      for (int f = 0; f < vecs[v].frames; f++) begin
        chk($sformatf("v%0d_f%0d_len", v, f), flen_seen[f], 1024);
        chk($sformatf("v%0d_f%0d_phi", v, f), phi_seen[f], tbl_m[f]);
        chk($sformatf("v%0d_f%0d_tidx", v, f), tidx_seen[f], f);
      end
      if (vecs[v].frames > 0) chk($sformatf("v%0d_span", v), span_seen[0], vecs[v].span);
      if (vecs[v].lat >= 0) chk($sformatf("v%0d_sop_latency", v), sop_cyc[0] - first_clken, vecs[v].lat);
      chk($sformatf("v%0d_busy_end", v), int'(busy), 0);
      chk($sformatf("v%0d_clken_end", v), int'(nco_clken), 0);
    end
    sv_mode   = 0;
    fft_ready = 1'b1;

    // Table write during CAPTURE must be ignored
    clear_mon();
    kick(2);
    wait_sops(1);
    wr(1, 32'h0000dead);
    wait_done();
    tick();
    chk("cfgwe_capture_ignored", phi_seen[1], tbl_m[1]);
    chk("cfgwe_capture_frames", eop_cnt, 2);

    // Stop at sample 500 of frame 2, then write right after
    clear_mon();
    kick(3);
    for (int i = 0; i < 20000; i++) begin
      if (sop_cnt == 2 && fcnt == 499) break;
      tick();
    end
    chk("stop_reached_sample", fcnt, 499);
    stop = 1'b1;
    @(negedge clk);
    chk("stop_valid_drop", int'(frame_valid), 0);
    chk("stop_no_eop", int'(frame_eop), 0);
    tick();
    stop = 1'b0;
    wr(1, 32'h00001234);
    chk("stop_busy", int'(busy), 0);
    chk("stop_clken", int'(nco_clken), 0);
    chk("stop_phi_hold", int'(phi_inc), tbl_m[1]);
    repeat (5) tick();
    chk("stop_no_done", done_cnt, 0);
    chk("stop_eops", eop_cnt, 1);
    tbl_m[1] = 32'h00001234;
    clear_mon();
    kick(2);
    wait_done();
    tick();
    chk("post_stop_write_phi", phi_seen[1], tbl_m[1]);

    // Asynchronous reset mid-frame
    clear_mon();
    kick(1);
    wait_sops(1);
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tbl_m[i] = 0;
    clear_mon();
    kick(1);
    wait_done();
    tick();
    chk("midreset_tbl_cleared", phi_seen[0], tbl_m[0]);
    chk("midreset_frames", eop_cnt, 1);

`ifdef TONE_SWEEP_LOOP_EN
    // Loop mode wraps back to tone 0 without a done pulse
    wr(0, 11);
    wr(1, 22);
    clear_mon();
    loop = 1'b1;
    kick(2);
    wait_sops(4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop = 1'b0;
    for (int f = 0; f < 4; f++) chk($sformatf("loop_tidx%0d", f), tidx_seen[f], f % 2);
    chk("loop_phi2", phi_seen[2], 11);
    chk("loop_no_done", done_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
